// File: rtl/network_population_runner.sv
// Streams each network's genome from external RAM, wires the neurons from the genes and runs every network of a population in turn.
// Optional per-output activity counters are compiled in when ACTIVITY_COUNT_EN is defined.
module network_population_runner #(
  parameter  int INPUT_COUNT             = 4,
  parameter  int OUTPUT_COUNT            = 2,
  parameter  int NEURON_COUNT            = 8,
  parameter  int CONNECTIONS             = 3,
  parameter  int THRESHOLD               = 2,
  parameter  int NETWORKS_PER_POPULATION = 16,
  parameter  int GENE_W                  = 16,
  parameter  int ADDR_W                  = 23,
  localparam int NET_W = (NETWORKS_PER_POPULATION > 1) ? $clog2(NETWORKS_PER_POPULATION) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [63:0]             run_cycles,
  input  logic [INPUT_COUNT-1:0]  nin,
  output logic [OUTPUT_COUNT-1:0] nout,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_req,
  input  logic                    ram_ack,
  input  logic [GENE_W-1:0]       ram_data,
  output logic [NET_W-1:0]        active_network,
  output logic                    busy,
  output logic                    network_done,
  output logic                    population_done
`ifdef ACTIVITY_COUNT_EN
  ,
  output logic [OUTPUT_COUNT*32-1:0] activity
`endif
);

  localparam int TOTAL_GENES = NEURON_COUNT * CONNECTIONS + OUTPUT_COUNT;
  localparam int NODES       = INPUT_COUNT + NEURON_COUNT;
  localparam int GCNT_W      = (TOTAL_GENES > 1) ? $clog2(TOTAL_GENES) : 1;
  localparam int OUT_BASE    = NEURON_COUNT * CONNECTIONS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic [GCNT_W-1:0]       gene_cnt_q, gene_cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [NET_W-1:0]        net_q, net_d;
  logic [63:0]             cyc_q, cyc_d;
  logic [63:0]             run_len_q, run_len_d;
  logic [GENE_W-1:0]       gene_q [TOTAL_GENES];
  logic [GENE_W-1:0]       gene_d [TOTAL_GENES];
  logic [NEURON_COUNT-1:0] neuron_q, neuron_d;
  logic [NEURON_COUNT-1:0] fire;
  logic [NODES-1:0]        node_vec;

  logic ack_take;
  logic last_gene;
  logic run_end;
  logic last_net;

  // Node numbering: external inputs first, then neuron outputs.
  assign node_vec  = {neuron_q, nin};
  assign ack_take  = (state_q == S_LOAD) && req_q && ram_ack;
  assign last_gene = (gene_cnt_q == GCNT_W'(TOTAL_GENES - 1));
  assign run_end   = (cyc_q == run_len_q - 64'd1);
  assign last_net  = (net_q == NET_W'(NETWORKS_PER_POPULATION - 1));

  // A select value outside the node range reads as constant 0.
  function automatic logic pick(input logic [GENE_W-1:0] sel, input logic [NODES-1:0] nodes);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      if (sel == GENE_W'(i)) r = nodes[i];
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default every comb output before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (ack_take && last_gene) state_d = S_RUN;
      S_RUN:  if (run_end) state_d = S_NEXT;
      S_NEXT: state_d = last_net ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Neuron evaluation from the current gene selects and node values.
  always_comb begin
    int act;
    act  = 0;
    fire = '0;
    for (int k = 0; k < NEURON_COUNT; k++) begin
      act = 0;
      for (int j = 0; j < CONNECTIONS; j++) begin
        act = act + int'(pick(gene_q[k*CONNECTIONS+j], node_vec));
      end
      fire[k] = (act >= THRESHOLD);
    end
  end

  // Datapath next values.
  always_comb begin
    req_d      = req_q;
    gene_cnt_d = gene_cnt_q;
    addr_d     = addr_q;
    net_d      = net_q;
    cyc_d      = cyc_q;
    run_len_d  = run_len_q;
    gene_d     = gene_q;
    neuron_d   = neuron_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          run_len_d  = (run_cycles == 64'd0) ? 64'd1 : run_cycles;
          net_d      = '0;
          gene_cnt_d = '0;
          req_d      = 1'b1;
        end
      end
      S_LOAD: begin
        if (ack_take) begin
          gene_d[gene_cnt_q] = ram_data;
          addr_d             = addr_q + ADDR_W'(1);
          req_d              = 1'b0;
          if (last_gene) begin
            gene_cnt_d = '0;
            cyc_d      = 64'd0;
            neuron_d   = '0;
          end else begin
            gene_cnt_d = gene_cnt_q + GCNT_W'(1);
          end
        end else if (!req_q) begin
          // One idle cycle after each ack, then request the next gene.
          req_d = 1'b1;
        end
      end
      S_RUN: begin
        neuron_d = fire;
        cyc_d    = cyc_q + 64'd1;
      end
      S_NEXT: begin
        if (!last_net) begin
          net_d      = net_q + NET_W'(1);
          gene_cnt_d = '0;
          req_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      gene_cnt_q <= '0;
      addr_q     <= '0;
      net_q      <= '0;
      cyc_q      <= 64'd0;
      run_len_q  <= 64'd0;
      // NOTE: the gene store is a register file, not RAM, so it is reset like any other flop.
      gene_q     <= '{default: '0};
      neuron_q   <= '0;
    end else begin
      req_q      <= req_d;
      gene_cnt_q <= gene_cnt_d;
      addr_q     <= addr_d;
      net_q      <= net_d;
      cyc_q      <= cyc_d;
      run_len_q  <= run_len_d;
      gene_q     <= gene_d;
      neuron_q   <= neuron_d;
    end
  end

  // Outputs
  always_comb begin
    ram_req         = (state_q == S_LOAD) && req_q;
    ram_addr        = addr_q;
    active_network  = net_q;
    busy            = (state_q != S_IDLE);
    network_done    = (state_q == S_NEXT);
    population_done = (state_q == S_NEXT) && last_net;
    nout            = '0;
    for (int o = 0; o < OUTPUT_COUNT; o++) begin
      nout[o] = (state_q == S_RUN) && pick(gene_q[OUT_BASE+o], node_vec);
    end
  end

`ifdef ACTIVITY_COUNT_EN
  logic [31:0] act_q [OUTPUT_COUNT];
  logic [31:0] act_d [OUTPUT_COUNT];

  // Lanes clear on RUN entry, count saturating during RUN, hold elsewhere.
  always_comb begin
    act_d = act_q;
    if (ack_take && last_gene) begin
      act_d = '{default: '0};
    end else if (state_q == S_RUN) begin
      for (int o = 0; o < OUTPUT_COUNT; o++) begin
        if (nout[o] && (act_q[o] != 32'hFFFF_FFFF)) act_d[o] = act_q[o] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) act_q <= '{default: '0};
    else     act_q <= act_d;
  end

  always_comb begin
    activity = '0;
    for (int o = 0; o < OUTPUT_COUNT; o++) activity[o*32 +: 32] = act_q[o];
  end
`endif

endmodule
